// File: rtl/game_sequencer.sv
// Game round sequencer: IDLE -> COUNTDOWN -> PLAY -> GAMEOVER, with per-player
// respawn hold, loot scoring and winner selection. One clock edge per video frame.
//
// Input semantics (no valid/ready handshake): Keycode is a level, and a start event
// is its rising match against START_KEY. P*Hit and P*Deposit are per-frame event
// qualifiers; a 1 sampled at a FrameClk edge is exactly one event. There is no
// backpressure, so an event that cannot be accepted is dropped.
module game_sequencer #(
  parameter int          FRAME_RATE        = 60,
  parameter int          COUNTDOWN_SECONDS = 3,
  parameter int          ROUND_SECONDS     = 90,
  parameter int          RESPAWN_FRAMES    = 60,
  parameter logic [7:0]  START_KEY         = 8'h28
) (
  input  logic       FrameClk,
  input  logic       Reset,
  input  logic [7:0] Keycode,
  input  logic       P1Hit,
  input  logic       P2Hit,
  input  logic       P1Deposit,
  input  logic       P2Deposit,
  output logic [1:0] GameState,
  output logic       SpawnEnable1,
  output logic       SpawnEnable2,
  output logic [1:0] CountdownVal,
  output logic [6:0] RoundTimer,
  output logic [7:0] P1Score,
  output logic [7:0] P2Score,
  output logic [1:0] Winner
);

  localparam int FW = (FRAME_RATE > 1) ? $clog2(FRAME_RATE) : 1;
  localparam int RW = $clog2(RESPAWN_FRAMES + 1);

  localparam logic [FW-1:0] FRAME_LAST   = FW'(FRAME_RATE - 1);
  localparam logic [RW-1:0] RESPAWN_LOAD = RW'(RESPAWN_FRAMES);
  localparam logic [1:0]    CD_LOAD      = 2'(COUNTDOWN_SECONDS);
  localparam logic [6:0]    RT_LOAD      = 7'(ROUND_SECONDS);

  // State encoding doubles as the GameState output, so the FSM is directly observable.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    COUNTDOWN = 2'b01,
    PLAY      = 2'b10,
    GAMEOVER  = 2'b11
  } state_t;

  state_t        state;
  logic [FW-1:0] frame_cnt;
  logic [RW-1:0] rsp1, rsp2;
  logic          prev_key;

  logic          key_match, start_evt, sec_tick, in_play, round_end, active, play_next;
  logic          hit1, hit2, dep1, dep2;
  logic [RW-1:0] rsp1_nxt, rsp2_nxt;

  assign GameState = state;

  // Event decode and next respawn counts; "active" excludes the final second tick
  // so hits and deposits landing on it are ignored.
  always_comb begin
    key_match = (Keycode == START_KEY);
    start_evt = key_match && !prev_key;
    sec_tick  = (frame_cnt == FRAME_LAST);
    in_play   = (state == PLAY);
    round_end = in_play && sec_tick && (RoundTimer <= 7'd1);
    active    = in_play && !round_end;
    play_next = active || ((state == COUNTDOWN) && sec_tick && (CountdownVal <= 2'd1));

    hit1 = active && P1Hit && (rsp1 == '0);
    hit2 = active && P2Hit && (rsp2 == '0);
    // A hit in the same frame wins over a deposit.
    dep1 = active && P1Deposit && !P1Hit && (rsp1 == '0);
    dep2 = active && P2Deposit && !P2Hit && (rsp2 == '0);

    rsp1_nxt = '0;
    if (hit1)                         rsp1_nxt = RESPAWN_LOAD;
    else if (active && rsp1 != '0)    rsp1_nxt = rsp1 - RW'(1);

    rsp2_nxt = '0;
    if (hit2)                         rsp2_nxt = RESPAWN_LOAD;
    else if (active && rsp2 != '0)    rsp2_nxt = rsp2 - RW'(1);
  end

  // Game FSM with all outputs registered; reset overrides everything.
  always_ff @(posedge FrameClk) begin
    if (Reset) begin
      state        <= IDLE;
      frame_cnt    <= '0;
      rsp1         <= '0;
      rsp2         <= '0;
      prev_key     <= 1'b0;
      SpawnEnable1 <= 1'b1;
      SpawnEnable2 <= 1'b1;
      CountdownVal <= 2'd0;
      RoundTimer   <= 7'd0;
      P1Score      <= 8'd0;
      P2Score      <= 8'd0;
      Winner       <= 2'b00;
    end else begin
      prev_key     <= key_match;
      rsp1         <= rsp1_nxt;
      rsp2         <= rsp2_nxt;
      SpawnEnable1 <= !play_next || (rsp1_nxt != '0);
      SpawnEnable2 <= !play_next || (rsp2_nxt != '0);
      frame_cnt    <= sec_tick ? '0 : frame_cnt + FW'(1);

      case (state)
        IDLE, GAMEOVER: begin
          if (start_evt) begin
            state        <= COUNTDOWN;
            frame_cnt    <= '0;
            CountdownVal <= CD_LOAD;
            P1Score      <= 8'd0;
            P2Score      <= 8'd0;
            Winner       <= 2'b00;
          end
        end
        COUNTDOWN: begin
          if (sec_tick) begin
            if (CountdownVal <= 2'd1) begin
              state        <= PLAY;
              frame_cnt    <= '0;
              CountdownVal <= 2'd0;
              RoundTimer   <= RT_LOAD;
            end else begin
              CountdownVal <= CountdownVal - 2'd1;
            end
          end
        end
        PLAY: begin
          if (round_end) begin
            state      <= GAMEOVER;
            frame_cnt  <= '0;
            RoundTimer <= 7'd0;
            if (P1Score > P2Score)      Winner <= 2'b01;
            else if (P2Score > P1Score) Winner <= 2'b10;
            else                        Winner <= 2'b11;
          end else begin
            if (sec_tick) RoundTimer <= RoundTimer - 7'd1;
            if (dep1 && P1Score != 8'hFF) P1Score <= P1Score + 8'd1;
            if (dep2 && P2Score != 8'hFF) P2Score <= P2Score + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with small timing parameters; a second
// instance with a long round exercises score saturation.
module tb_game_sequencer;

  localparam int         FR = 4;
  localparam int         CD = 2;
  localparam int         RS = 3;
  localparam int         RF = 5;
  localparam logic [7:0] SK = 8'h28;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] key;
  logic       p1h, p2h, p1d, p2d;
  logic [1:0] gs, cd, win;
  logic       s1, s2;
  logic [6:0] rt;
  logic [7:0] p1s, p2s;

  logic [7:0] l_key;
  logic       l_zero, l_p2d;
  logic [1:0] l_gs, l_cd, l_win;
  logic       l_s1, l_s2;
  logic [6:0] l_rt;
  logic [7:0] l_p1s, l_p2s;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  game_sequencer #(
    .FRAME_RATE(FR), .COUNTDOWN_SECONDS(CD), .ROUND_SECONDS(RS),
    .RESPAWN_FRAMES(RF), .START_KEY(SK)
  ) dut (
    .FrameClk(clk), .Reset(rst), .Keycode(key),
    .P1Hit(p1h), .P2Hit(p2h), .P1Deposit(p1d), .P2Deposit(p2d),
    .GameState(gs), .SpawnEnable1(s1), .SpawnEnable2(s2),
    .CountdownVal(cd), .RoundTimer(rt), .P1Score(p1s), .P2Score(p2s), .Winner(win)
  );

  game_sequencer #(
    .FRAME_RATE(FR), .COUNTDOWN_SECONDS(CD), .ROUND_SECONDS(90),
    .RESPAWN_FRAMES(RF), .START_KEY(SK)
  ) dut_long (
    .FrameClk(clk), .Reset(rst), .Keycode(l_key),
    .P1Hit(l_zero), .P2Hit(l_zero), .P1Deposit(l_zero), .P2Deposit(l_p2d),
    .GameState(l_gs), .SpawnEnable1(l_s1), .SpawnEnable2(l_s2),
    .CountdownVal(l_cd), .RoundTimer(l_rt), .P1Score(l_p1s), .P2Score(l_p2s), .Winner(l_win)
  );

  // Scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    key = 8'h00; p1h = 1'b0; p2h = 1'b0; p1d = 1'b0; p2d = 1'b0;
  endtask

  task automatic press_start();
    key = SK;
    tick(1);
    key = 8'h00;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
    int c;
    c = 0;
    while (gs !== s && c < budget) begin
      tick(1);
      c++;
    end
    chk(tag, gs, s);
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_gs"},  gs,  2'b00);
    chk({t, "_sp1"}, s1,  1'b1);
    chk({t, "_sp2"}, s2,  1'b1);
    chk({t, "_cd"},  cd,  2'd0);
    chk({t, "_rt"},  rt,  7'd0);
    chk({t, "_p1s"}, p1s, 8'd0);
    chk({t, "_p2s"}, p2s, 8'd0);
    chk({t, "_win"}, win, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e;
    int c;
    rst = 1'b1;
    idle_inputs();
    l_key = 8'h00; l_zero = 1'b0; l_p2d = 1'b0;
    tick(2);
    chk_reset("reset");
    rst = 1'b0;
    tick(1);
    chk("idle_hold", gs, 2'b00);

    // Start flow: one-cycle key press from IDLE
    press_start();
    chk("start_gs", gs, 2'b01);
    chk("start_cd", cd, 2'd2);
    chk("start_sp1", s1, 1'b1);
    tick(3);
    chk("cd_e3", cd, 2'd2);
    tick(1);
    chk("cd_e4", cd, 2'd1);
    tick(3);
    chk("cd_e7_gs", gs, 2'b01);
    tick(1);
    chk("play_gs", gs, 2'b10);
    chk("play_rt", rt, 7'd3);
    chk("play_cd", cd, 2'd0);
    chk("play_sp1", s1, 1'b0);
    chk("play_sp2", s2, 1'b0);
    tick(4);
    chk("rt_e12", rt, 7'd2);
    tick(7);
    chk("rt_e19_gs", gs, 2'b10);
    chk("rt_e19", rt, 7'd1);
    tick(1);
    chk("over_gs", gs, 2'b11);
    chk("over_rt", rt, 7'd0);
    chk("over_win_tie0", win, 2'b11);
    chk("over_sp1", s1, 1'b1);

    // Held key from IDLE: 20 edges, exactly one start
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    key = SK;
    tick(1);
    chk("held_gs0", gs, 2'b01);
    chk("held_cd0", cd, 2'd2);
    tick(6);
    chk("held_gs6", gs, 2'b01);
    chk("held_cd6", cd, 2'd1);
    tick(2);
    chk("held_play", gs, 2'b10);
    chk("held_rt", rt, 7'd3);
    tick(11);
    chk("held_rt19", rt, 7'd1);
    key = 8'h00;
    tick(1);
    chk("held_over", gs, 2'b11);

    // Restart from GAMEOVER, then key held across round end
    press_start();
    chk("restart_gs", gs, 2'b01);
    chk("restart_win", win, 2'b00);
    tick(8);
    chk("f8_play", gs, 2'b10);
    tick(2);
    key = SK;
    tick(1);
    chk("play_ignore_start_gs", gs, 2'b10);
    chk("play_ignore_start_rt", rt, 7'd3);
    tick(9);
    chk("f20_over", gs, 2'b11);
    tick(4);
    chk("held_in_over", gs, 2'b11);
    key = 8'h00;
    tick(1);
    chk("released_over", gs, 2'b11);
    key = SK;
    tick(1);
    chk("repress_gs", gs, 2'b01);
    key = 8'h00;

    // Reset mid-countdown wins over a fresh key press
    tick(2);
    rst = 1'b1;
    key = SK;
    tick(1);
    chk("rst_cd_gs", gs, 2'b00);
    chk("rst_cd_cd", cd, 2'd0);
    rst = 1'b0;
    key = 8'h00;
    tick(1);
    chk("rst_cd_idle", gs, 2'b00);

    // Respawn window
    press_start();
    tick(8);
    chk("rsp_play", gs, 2'b10);
    chk("rsp_sp1_pre", s1, 1'b0);
    p1h = 1'b1;
    tick(1);
    p1h = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0000);
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      chk("rsp_window", {14'd0, s1, s2}, e);
      p1h = (i == 1);
      p1d = (i == 2);
      if (i < 5) tick(1);
    end
    p1h = 1'b0;
    p1d = 1'b0;
    chk("rsp_dep_dropped", p1s, 8'd0);
    p1d = 1'b1;
    tick(1);
    p1d = 1'b0;
    chk("rsp_dep_after", p1s, 8'd1);
    wait_state(2'b11, 20, "rsp_over");
    chk("p1_wins", win, 2'b01);

    // Scoring and tie
    press_start();
    tick(8);
    p1d = 1'b1;
    tick(1);
    p1d = 1'b0; p2d = 1'b1;
    tick(1);
    p1d = 1'b1; p2d = 1'b1;
    tick(1);
    chk("score_p1_both", p1s, 8'd2);
    chk("score_p2_both", p2s, 8'd2);
    p2d = 1'b0; p1h = 1'b1; p1d = 1'b1;
    tick(1);
    p1h = 1'b0; p1d = 1'b0;
    chk("hit_beats_dep", p1s, 8'd2);
    chk("hit_sp1", s1, 1'b1);
    chk("hit_sp2", s2, 1'b0);
    tick(7);
    chk("tie_rt1", rt, 7'd1);
    p2d = 1'b1; p1h = 1'b1;
    tick(1);
    p2d = 1'b0; p1h = 1'b0;
    chk("tie_gs", gs, 2'b11);
    chk("final_tick_dep", p2s, 8'd2);
    chk("tie_win", win, 2'b11);
    chk("tie_rt0", rt, 7'd0);

    // Reset mid-play while P1 respawns
    press_start();
    tick(8);
    p1h = 1'b1; p2d = 1'b1;
    tick(1);
    p1h = 1'b0; p2d = 1'b0;
    chk("mid_sp1", s1, 1'b1);
    chk("mid_p2s", p2s, 8'd1);
    tick(1);
    rst = 1'b1; p1h = 1'b1; p1d = 1'b1; p2d = 1'b1;
    tick(1);
    chk_reset("rst_play");
    rst = 1'b0;
    idle_inputs();
    tick(1);
    chk("rst_play_idle", gs, 2'b00);

    // Long round: saturation and P2 winner
    l_key = SK;
    tick(1);
    l_key = 8'h00;
    tick(8);
    chk("long_play", l_gs, 2'b10);
    l_p2d = 1'b1;
    tick(300);
    l_p2d = 1'b0;
    chk("long_sat", l_p2s, 8'd255);
    c = 0;
    while (l_gs !== 2'b11 && c < 100) begin
      tick(1);
      c++;
    end
    chk("long_over", l_gs, 2'b11);
    chk("long_win", l_win, 2'b10);
    chk("long_p2s", l_p2s, 8'd255);
    chk("long_p1s", l_p1s, 8'd0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL expose the following parameters, one per line as name, default, meaning:
- FRAME_RATE, 60, FrameClk cycles per game second.
- COUNTDOWN_SECONDS, 3, pre-round countdown length.
- ROUND_SECONDS, 90, round length.
- RESPAWN_FRAMES, 60, frames a hit player is held at spawn.
- START_KEY, 8'h28, keycode that starts a game.
REQ-002 The block SHALL expose the following ports, one per line as name, direction, width, meaning:
- FrameClk, in, 1, the single clock, one edge per video frame.
- Reset, in, 1, synchronous active-high reset.
- Keycode, in, 8, current keyboard keycode.
- P1Hit / P2Hit, in, 1 each, collision with a hazard this frame.
- P1Deposit / P2Deposit, in, 1 each, player banked loot this frame.
- GameState, out, 2, 00 IDLE, 01 COUNTDOWN, 10 PLAY, 11 GAMEOVER.
- SpawnEnable1 / SpawnEnable2, out, 1 each, 1 = hold player at spawn.
- CountdownVal, out, 2, seconds remaining in countdown.
- RoundTimer, out, 7, seconds remaining in round.
- P1Score / P2Score, out, 8 each, banked loot count.
- Winner, out, 2, 01 P1, 10 P2, 11 tie, 00 none.

Function
REQ-003 All state SHALL update on the rising edge of FrameClk only; every output SHALL be registered.
REQ-004 The start event SHALL be a rising edge of (Keycode == START_KEY), i.e. the match this cycle with no match in the previous cycle; a held key SHALL produce exactly one start event.
REQ-005 A free-running frame counter SHALL count 0..FRAME_RATE-1 and wrap; SecTick SHALL be asserted when it equals FRAME_RATE-1. The counter SHALL clear on every state transition.
REQ-006 IDLE: on a start event, the block SHALL go to COUNTDOWN next cycle, load CountdownVal = COUNTDOWN_SECONDS, and clear both scores and Winner.
REQ-007 COUNTDOWN: on SecTick with CountdownVal > 1, CountdownVal SHALL decrement.
REQ-008 COUNTDOWN: on SecTick with CountdownVal == 1, the block SHALL go to PLAY, set CountdownVal = 0, and load RoundTimer = ROUND_SECONDS.
REQ-009 PLAY: on SecTick with RoundTimer > 1, RoundTimer SHALL decrement.
REQ-010 PLAY: on SecTick with RoundTimer == 1, the block SHALL go to GAMEOVER, set RoundTimer = 0, and set Winner in the same cycle from the final scores (greater score wins; equal scores give 11).
REQ-011 GAMEOVER: all outputs SHALL hold; a start event SHALL behave exactly as in IDLE (REQ-006).
REQ-012 Start events in COUNTDOWN and PLAY SHALL be ignored.
REQ-013 Each player SHALL have a respawn counter sized for RESPAWN_FRAMES.
REQ-014 In PLAY, a hit with that player's counter == 0 SHALL load the counter with RESPAWN_FRAMES on the next cycle; while the counter is nonzero it SHALL decrement by one per cycle and further hits SHALL be ignored.
REQ-015 SpawnEnableN SHALL be 1 in IDLE, COUNTDOWN and GAMEOVER; in PLAY it SHALL equal (respawn counter N != 0).
REQ-016 In PLAY, a deposit with that player's respawn counter == 0 SHALL increment the score, saturating at 255; deposits in other states or during respawn SHALL be dropped.
REQ-017 A hit and a deposit by the same player in the same cycle: the hit SHALL take effect and the deposit SHALL be dropped.
REQ-018 The two players SHALL be processed independently; simultaneous events from both players SHALL both take effect.
REQ-019 On leaving PLAY, both respawn counters SHALL clear; a hit or deposit on the final SecTick cycle SHALL be ignored.

Reset
REQ-020 While Reset = 1 at a clock edge, the block SHALL enter IDLE and set:
- GameState = 00, SpawnEnable1 = SpawnEnable2 = 1;
- CountdownVal = 0, RoundTimer = 0, P1Score = P2Score = 0, Winner = 00;
- frame counter, respawn counters and previous-key flag = 0.
REQ-021 Reset SHALL take priority over every other input in every state, including mid-countdown and mid-respawn.

Verification
REQ-022 The bench SHALL use FRAME_RATE=4, COUNTDOWN_SECONDS=2, ROUND_SECONDS=3, RESPAWN_FRAMES=5, and SHALL cover the following scenarios:
- Start flow: Keycode=28 for 1 cycle in IDLE -> GameState=01 and CountdownVal=2 next cycle; 10 at +8 cycles with RoundTimer=3; 11 at +12 further cycles with RoundTimer=0.
- Held key: Keycode=28 held for 20 cycles from IDLE -> exactly one start event; no restart in GAMEOVER until the key is released and pressed again.
- Respawn: P1Hit in PLAY -> SpawnEnable1=1 for exactly 5 cycles; a second P1Hit during that window has no effect; SpawnEnable2 stays 0.
- Scoring/tie: P1Deposit x2, P2Deposit x2, plus P1Hit and P1Deposit in the same cycle -> P1Score=2, P2Score=2, Winner=11 at GAMEOVER.
- Saturation/winner: 300 P2Deposit pulses in a long round -> P2Score=255; Winner=10.
- Reset mid-play: Reset during PLAY with P1 respawning -> next cycle GameState=00, all outputs at their REQ-020 values.
